// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter granting one of fetch/load/store requesters a single
// outstanding DRAM transaction. Optional watchdog: define MEM_ARB_TIMEOUT_EN.
module memory_bus_arbiter #(
  parameter int unsigned ADDR_W         = 21,
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          req_valid,
  input  logic [2:0]          req_write,
  input  logic [3*ADDR_W-1:0] req_addr,
  input  logic [3*DATA_W-1:0] req_wdata,
  output logic [2:0]          req_ready,
  output logic [2:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_error,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_write,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_e;

  state_e              state_q, state_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic [1:0]          owner_q, owner_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                mem_req_valid_q, mem_req_valid_d;
  logic [2:0]          rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_error_q, rsp_error_d;
  logic [2:0]          req_ready_c;

  logic [ADDR_W-1:0]   addr_a  [3];
  logic [DATA_W-1:0]   wdata_a [3];
  logic                grant_c;
  logic [1:0]          grant_idx_c;
  logic [1:0]          scan_idx_c;
  logic [2:0]          scan_sum_c;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  for (genvar g = 0; g < 3; g++) begin : g_slice
    assign addr_a[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_a[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  // First requesting slot at or after rr_ptr, wrapping mod 3
  always_comb begin
    grant_c     = 1'b0;
    grant_idx_c = 2'd0;
    scan_idx_c  = 2'd0;
    scan_sum_c  = 3'd0;
    for (int k = 0; k < 3; k++) begin
      scan_sum_c = {1'b0, rr_ptr_q} + 3'(k);
      scan_idx_c = (scan_sum_c >= 3'd3) ? 2'(scan_sum_c - 3'd3) : scan_sum_c[1:0];
      if (!grant_c && req_valid[scan_idx_c]) begin
        grant_c     = 1'b1;
        grant_idx_c = scan_idx_c;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      rr_ptr_q        <= 2'd0;
      owner_q         <= 2'd0;
      write_q         <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      mem_req_valid_q <= 1'b0;
      rsp_valid_q     <= 3'd0;
      rsp_rdata_q     <= '0;
      rsp_error_q     <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q           <= '0;
`endif
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      owner_q         <= owner_d;
      write_q         <= write_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      mem_req_valid_q <= mem_req_valid_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_rdata_q     <= rsp_rdata_d;
      rsp_error_q     <= rsp_error_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q           <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    owner_d         = owner_q;
    write_d         = write_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    mem_req_valid_d = mem_req_valid_q;
    rsp_valid_d     = 3'd0;
    rsp_rdata_d     = '0;
    rsp_error_d     = 1'b0;
    req_ready_c     = 3'd0;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d           = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        // Acceptance is a same-cycle pulse; masked while reset is held
        if (grant_c && !reset) begin
          req_ready_c     = 3'b001 << grant_idx_c;
          owner_d         = grant_idx_c;
          write_d         = req_write[grant_idx_c];
          addr_d          = addr_a[grant_idx_c];
          wdata_d         = wdata_a[grant_idx_c];
          rr_ptr_d        = (grant_idx_c == 2'd2) ? 2'd0 : grant_idx_c + 2'd1;
          mem_req_valid_d = 1'b1;
          state_d         = ISSUE;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d           = '0;
`endif
        end
      end
      ISSUE: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          state_d         = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (mem_rsp_valid) begin
          rsp_valid_d = 3'b001 << owner_q;
          rsp_rdata_d = write_q ? '0 : mem_rsp_rdata;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef MEM_ARB_TIMEOUT_EN
    // A real response in the final cycle wins over the watchdog
    if (state_q == ISSUE || state_q == WAIT_RSP) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1) &&
          !(state_q == WAIT_RSP && mem_rsp_valid)) begin
        rsp_valid_d     = 3'b001 << owner_q;
        rsp_rdata_d     = '0;
        rsp_error_d     = 1'b1;
        mem_req_valid_d = 1'b0;
        state_d         = IDLE;
      end
    end
`endif
  end

  assign req_ready     = req_ready_c;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_error     = rsp_error_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_write = write_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;

endmodule
